// File: rtl/instr_fetch_unit_pkg.sv
// Shared MIPS front-end constants, IF/ID record and jump-opcode helpers.
// Pure definitions: no latency. No backpressure: nothing here holds state.
// The package is named mips_pkg so that later pipeline stages can share it.
package mips_pkg;

    localparam logic [5:0]  OP_J             = 6'h02;
    localparam logic [5:0]  OP_JAL           = 6'h03;
    localparam logic [31:0] NOP_WORD         = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc_plus4;
        logic        valid;
    } ifid_t;

    typedef enum logic [1:0] {
        IFID_LOAD  = 2'd0,
        IFID_HOLD  = 2'd1,
        IFID_FLUSH = 2'd2
    } ifid_op_t;

    function automatic logic is_jump(input logic [31:0] word);
        return (word[31:26] == OP_J) || (word[31:26] == OP_JAL);
    endfunction

    // The J-type target keeps the 256 MB region of the delay-slot address.
    function automatic logic [31:0] jump_target(input logic [31:0] pc_plus4,
                                                input logic [31:0] word);
        return {pc_plus4[31:28], word[25:0], 2'b00};
    endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bus: hazard/redirect controls, instruction memory port, IF/ID outputs.
// Pure wiring: no latency. Backpressure arrives only as the stall level.
// master = fetch unit side, slave = surrounding pipeline / memory side.
interface instr_fetch_unit_if;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc_plus4;
    logic        ifid_valid;

    modport master (
        input  stall, redirect, redirect_pc, imem_instr,
        output imem_addr, ifid_instr, ifid_pc_plus4, ifid_valid
    );

    modport slave (
        output stall, redirect, redirect_pc, imem_instr,
        input  imem_addr, ifid_instr, ifid_pc_plus4, ifid_valid
    );
endinterface

// File: rtl/if_id_register.sv
// IF/ID pipeline holding register with load, hold and flush operations.
// Latency: one clock from fetch to decode. Backpressure: IFID_HOLD freezes contents.
module if_id_register #(
    parameter logic [31:0] NOP_WORD = mips_pkg::NOP_WORD
) (
    input  logic               clk,
    input  logic               reset,
    input  mips_pkg::ifid_op_t op,
    input  logic [31:0]        instr,
    input  logic [31:0]        pc_plus4,
    output mips_pkg::ifid_t    q
);
    import mips_pkg::*;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q.instr    <= NOP_WORD;
            q.pc_plus4 <= 32'd0;
            q.valid    <= 1'b0;
        end else begin
            case (op)
                IFID_LOAD: begin
                    q.instr    <= instr;
                    q.pc_plus4 <= pc_plus4;
                    q.valid    <= 1'b1;
                end
                // A flushed slot carries a bubble so decode never sees the wrong-path word.
                IFID_FLUSH: begin
                    q.instr    <= NOP_WORD;
                    q.pc_plus4 <= 32'd0;
                    q.valid    <= 1'b0;
                end
                default: begin
                    q <= q;
                end
            endcase
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// MIPS fetch stage: PC register, next-PC select, IF/ID register; EARLY_JUMP_EN adds j/jal shortcut.
// Latency: imem_addr is the PC (0 cycles); fetched word reaches IF/ID one cycle later.
// Backpressure: stall holds PC and IF/ID; redirect overrides stall and flushes IF/ID.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = mips_pkg::RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_WORD = mips_pkg::NOP_WORD
) (
    input  logic                clk,
    input  logic                reset,
    instr_fetch_unit_if.master  f
);
    import mips_pkg::*;

    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] next_pc;
    ifid_op_t    ifid_op;
    ifid_t       ifid_q;

    assign pc_plus4    = pc + 32'd4;
    assign f.imem_addr = pc;

    // Priority: redirect, then stall, then (optionally) early jump, then sequential.
    always_comb begin
        next_pc = pc_plus4;
        ifid_op = IFID_LOAD;
        if (f.redirect) begin
            next_pc = f.redirect_pc;
            ifid_op = IFID_FLUSH;
        end else if (f.stall) begin
            next_pc = pc;
            ifid_op = IFID_HOLD;
        end else begin
`ifdef EARLY_JUMP_EN
            if (is_jump(f.imem_instr)) begin
                next_pc = jump_target(pc_plus4, f.imem_instr);
            end
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc <= RESET_PC;
        end else begin
            pc <= next_pc;
        end
    end

    if_id_register #(
        .NOP_WORD (NOP_WORD)
    ) u_if_id (
        .clk      (clk),
        .reset    (reset),
        .op       (ifid_op),
        .instr    (f.imem_instr),
        .pc_plus4 (pc_plus4),
        .q        (ifid_q)
    );

    assign f.ifid_instr    = ifid_q.instr;
    assign f.ifid_pc_plus4 = ifid_q.pc_plus4;
    assign f.ifid_valid    = ifid_q.valid;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios plus randomized stall/redirect traffic
// against a cycle-level reference model of the fetch rules (EARLY_JUMP_EN aware).
module tb_instr_fetch_unit;

    logic clk;
    logic reset;
    int   tests;
    int   fails;

    instr_fetch_unit_if ifu();

    instr_fetch_unit #(
        .RESET_PC (32'h0040_0000),
        .NOP_WORD (32'h0000_0000)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .f     (ifu)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory: a few pinned words, otherwise a hash of the address.
    // Below 0x01000000 hashed words never decode as j/jal so directed paths stay sequential.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] h;
        case (a)
            32'h0040_0000: return 32'h3c01_1001;
            32'h0040_01E8: return 32'h0c10_0086;
            32'hFFFF_FFFC: return 32'h2108_0001;
            default: ;
        endcase
        h = (a ^ 32'h5bd1_e995) * 32'h9E37_79B1;
        h = h ^ (h >> 15);
        if (a < 32'h0100_0000 && (h[31:26] == 6'h02 || h[31:26] == 6'h03))
            h[31:26] = 6'h08;
        return h;
    endfunction

    assign ifu.imem_instr = mem_word(ifu.imem_addr);

    // Reference model state: architectural PC and the IF/ID contents.
    logic [31:0] m_pc, m_instr, m_pp4;
    logic        m_valid;

    task automatic model_reset();
        m_pc    = 32'h0040_0000;
        m_instr = 32'h0;
        m_pp4   = 32'h0;
        m_valid = 1'b0;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp_model();
        check("imem_addr",     ifu.imem_addr,           m_pc);
        check("ifid_instr",    ifu.ifid_instr,          m_instr);
        check("ifid_pc_plus4", ifu.ifid_pc_plus4,       m_pp4);
        check("ifid_valid",    {31'd0, ifu.ifid_valid}, {31'd0, m_valid});
    endtask

    // One clock edge: model computes the next state from the pre-edge inputs, then compare.
    task automatic step();
        logic [31:0] n_pc, n_instr, n_pp4, w;
        logic        n_valid;
        n_pc = m_pc; n_instr = m_instr; n_pp4 = m_pp4; n_valid = m_valid;
        if (ifu.redirect) begin
            n_pc = ifu.redirect_pc; n_instr = 32'h0; n_pp4 = 32'h0; n_valid = 1'b0;
        end else if (!ifu.stall) begin
            w       = mem_word(m_pc);
            n_instr = w;
            n_pp4   = m_pc + 32'd4;
            n_valid = 1'b1;
            n_pc    = m_pc + 32'd4;
`ifdef EARLY_JUMP_EN
            if (w[31:26] == 6'h02 || w[31:26] == 6'h03)
                n_pc = {n_pp4[31:28], w[25:0], 2'b00};
`endif
        end
        @(posedge clk);
        #1;
        m_pc = n_pc; m_instr = n_instr; m_pp4 = n_pp4; m_valid = n_valid;
        cmp_model();
    endtask

    task automatic set_in(input logic s, input logic r, input logic [31:0] rpc);
        ifu.stall       = s;
        ifu.redirect    = r;
        ifu.redirect_pc = rpc;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b1;
        set_in(1'b0, 1'b0, 32'h0);
        model_reset();

        // Reset state, and no capture while reset is held across edges.
        #12;
        check("rst_imem_addr", ifu.imem_addr, 32'h0040_0000);
        check("rst_ifid_valid", {31'd0, ifu.ifid_valid}, 32'd0);
        check("rst_ifid_pc_plus4", ifu.ifid_pc_plus4, 32'h0);
        check("rst_ifid_instr", ifu.ifid_instr, 32'h0);
        reset = 1'b0;

        // First fetch after reset release.
        step();
        check("first_instr", ifu.ifid_instr, 32'h3c01_1001);
        check("first_pp4", ifu.ifid_pc_plus4, 32'h0040_0004);
        check("first_valid", {31'd0, ifu.ifid_valid}, 32'd1);
        check("first_next_addr", ifu.imem_addr, 32'h0040_0004);

        // Walk to 0x00400010, then stall two cycles.
        repeat (3) step();
        check("pre_stall_addr", ifu.imem_addr, 32'h0040_0010);
        set_in(1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 2; i++) begin
            step();
            check("stall_addr", ifu.imem_addr, 32'h0040_0010);
            check("stall_pp4", ifu.ifid_pc_plus4, 32'h0040_0010);
        end
        set_in(1'b0, 1'b0, 32'h0);
        step();
        check("post_stall_addr", ifu.imem_addr, 32'h0040_0014);
        check("post_stall_pp4", ifu.ifid_pc_plus4, 32'h0040_0014);

        // Redirect wins over stall and flushes IF/ID.
        set_in(1'b1, 1'b1, 32'h0040_0108);
        step();
        check("redir_addr", ifu.imem_addr, 32'h0040_0108);
        check("redir_instr", ifu.ifid_instr, 32'h0);
        check("redir_valid", {31'd0, ifu.ifid_valid}, 32'd0);

        // jal at 0x004001E8: early jump build follows the target, else sequential.
        set_in(1'b0, 1'b1, 32'h0040_01E8);
        step();
        set_in(1'b0, 1'b0, 32'h0);
        step();
        check("jal_instr", ifu.ifid_instr, 32'h0c10_0086);
        check("jal_pp4", ifu.ifid_pc_plus4, 32'h0040_01EC);
        check("jal_valid", {31'd0, ifu.ifid_valid}, 32'd1);
`ifdef EARLY_JUMP_EN
        check("jal_next_addr", ifu.imem_addr, 32'h0040_0218);
`else
        check("jal_next_addr", ifu.imem_addr, 32'h0040_01EC);
`endif

        // PC wrap at the top of the address space.
        set_in(1'b0, 1'b1, 32'hFFFF_FFFC);
        step();
        set_in(1'b0, 1'b0, 32'h0);
        step();
        check("wrap_addr", ifu.imem_addr, 32'h0);
        check("wrap_pp4", ifu.ifid_pc_plus4, 32'h0);

        // Back-to-back redirects, unaligned target bits pass through.
        set_in(1'b0, 1'b1, 32'h0040_0a03);
        step();
        set_in(1'b1, 1'b1, 32'h0040_0c01);
        step();
        check("b2b_addr", ifu.imem_addr, 32'h0040_0c01);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] tgt;
            tgt = ($urandom_range(1) == 0) ? $urandom : (32'h0040_0000 + $urandom_range(16'hffff));
            set_in($urandom_range(3) == 0, $urandom_range(9) == 0, tgt);
            step();
        end

        // Reset asserted mid-stall and mid-redirect takes effect immediately.
        set_in(1'b1, 1'b1, 32'h1234_5678);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check("async_rst_addr", ifu.imem_addr, 32'h0040_0000);
        check("async_rst_valid", {31'd0, ifu.ifid_valid}, 32'd0);
        @(posedge clk);
        #1;
        cmp_model();
        reset = 1'b0;
        set_in(1'b0, 1'b0, 32'h0);
        step();
        check("rerun_instr", ifu.ifid_instr, 32'h3c01_1001);
        check("rerun_addr", ifu.imem_addr, 32'h0040_0004);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0040_0000, PC value loaded on reset.
REQ-002 SHALL have parameter NOP_WORD, default 32'h0000_0000, instruction inserted as a bubble.
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-005 SHALL have port stall, input, 1, hazard-unit hold request (load-use).
REQ-006 SHALL have port redirect, input, 1, taken branch/jump/jr from a later stage.
REQ-007 SHALL have port redirect_pc, input, 32, target PC for the redirect.
REQ-008 SHALL have port imem_addr, output, 32, current PC driven to instruction memory.
REQ-009 SHALL have port imem_instr, input, 32, combinational instruction word returned for imem_addr.
REQ-010 SHALL have port ifid_instr, output, 32, registered instruction to decode.
REQ-011 SHALL have port ifid_pc_plus4, output, 32, registered PC+4 of ifid_instr.
REQ-012 SHALL have port ifid_valid, output, 1, ifid_instr is a real instruction (0 = bubble).

Function
REQ-013 SHALL drive imem_addr directly from the PC register, with no added latency.
REQ-014 SHALL compute pc_plus4 as PC + 32'd4, 32-bit modulo (32'hFFFF_FFFC wraps to 0).
REQ-015 SHALL use next-PC priority redirect > stall > early jump (REQ-026) > pc_plus4.
REQ-016 On redirect, SHALL load PC <= redirect_pc and IF/ID <= {NOP_WORD, 0, valid=0} in the same edge, regardless of stall.
REQ-017 On stall without redirect, SHALL hold PC and all IF/ID outputs unchanged.
REQ-018 Otherwise, SHALL load IF/ID <= {imem_instr, pc_plus4, valid=1} and advance PC.
REQ-019 SHALL have one-cycle fetch latency: an instruction at imem_addr in cycle N appears on ifid_instr in cycle N+1.
REQ-020 SHALL pass redirect_pc[1:0] unchanged; alignment checking belongs to later stages.
REQ-021 Back-to-back redirects SHALL each take effect; the last edge wins.
REQ-022 SHALL not latch imem_instr while reset is asserted.

Reset
REQ-023 SHALL reset asynchronously: PC=RESET_PC, ifid_instr=NOP_WORD, ifid_pc_plus4=0, ifid_valid=0.
REQ-024 Reset asserted mid-stall or mid-redirect SHALL override both immediately.
REQ-025 After reset deasserts, the first fetch SHALL be from RESET_PC on the next rising edge.

Configuration
REQ-026 With EARLY_JUMP_EN defined:
- When IF/ID loads per REQ-018 and imem_instr[31:26] is 6'h02 (j) or 6'h03 (jal), next PC SHALL be {pc_plus4[31:28], imem_instr[25:0], 2'b00}.
- The jump instruction SHALL still enter IF/ID with valid=1, so the jal link is preserved.
- Redirect and stall SHALL still take priority.
REQ-027 Without EARLY_JUMP_EN, SHALL have no opcode decode; j/jal SHALL resolve only via redirect.

Structure
REQ-028 Shared package mips_pkg SHALL hold OP_J, OP_JAL, NOP_WORD, and the default RESET_PC.
REQ-029 The IF/ID holding register (load/hold/flush) SHALL be sub-module if_id_register.
REQ-030 PC register and next-PC mux SHALL stay in instr_fetch_unit.

Verification
REQ-031 The bench SHALL cover reset release with memory returning 32'h3c011001 at 0x00400000:
- Expected: imem_addr=0x00400000, then ifid_instr=32'h3c011001, ifid_pc_plus4=0x00400004, valid=1.
REQ-032 The bench SHALL cover stall held 2 cycles at PC=0x00400010:
- Expected: imem_addr and IF/ID outputs unchanged for 2 cycles, then PC advances to 0x00400014.
REQ-033 The bench SHALL cover redirect=1 and stall=1 together with redirect_pc=0x00400108:
- Expected: PC=0x00400108, ifid_instr=0, valid=0 next cycle.
REQ-034 The bench SHALL cover EARLY_JUMP_EN with 32'h0c100086 fetched at 0x004001E8:
- Expected: next imem_addr=0x00400218; IF/ID holds the jal with pc_plus4=0x004001EC.
REQ-035 The bench SHALL cover EARLY_JUMP_EN off with the same word:
- Expected: next imem_addr=0x004001EC.
REQ-036 The bench SHALL cover PC=32'hFFFF_FFFC with no stall/redirect:
- Expected: next imem_addr=0, ifid_pc_plus4=0.
